// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: pops BURST_LEN-word bursts from a synchronous FIFO onto a
// valid/ready stream. Define FIFO_RD_TIMEOUT_EN to flush partial bursts after TIMEOUT_CYCLES.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        busy,
  output logic                        burst_done
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] BurstLen = CntW'(BURST_LEN);

  if ((BURST_LEN < 1) || (BURST_LEN > FIFO_DEPTH) || (TIMEOUT_CYCLES < 1)) begin : g_param_err
    $error("fifo_burst_reader: illegal BURST_LEN/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         burst_len_q, burst_len_d;
  logic [CntW-1:0]         issued_q, issued_d;
  logic [CntW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                    inflight_q;
  logic [1:0]              buf_occ_q, buf_occ_d;
  logic [DATA_WIDTH-1:0]   buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;
  logic                    burst_done_q, burst_done_d;
  logic                    pop;
  logic [2:0]              credit;
  logic                    tmo_hit;

  // Head of the skid buffer drives the stream.
  always_comb begin
    m_valid    = (buf_occ_q != 2'd0);
    m_data     = buf0_q;
    m_last     = m_valid && (beat_cnt_q == burst_len_q - CntW'(1));
    pop        = m_valid && m_ready;
    busy       = (state_q != StIdle);
    burst_done = burst_done_q;
  end

  // Words already buffered plus the one in flight must fit the 2-entry buffer.
  always_comb begin
    credit     = 3'(buf_occ_q) + 3'(inflight_q) - 3'(pop);
    fifo_rd_en = (state_q == StDrain) && (issued_q < burst_len_q) &&
                 (fifo_count != '0) && (credit < 3'd2);
  end

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            partial;

  always_comb begin
    partial = (state_q == StIdle) && (fifo_count != '0) && (fifo_count < BurstLen);
    tmo_hit = partial && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    tmo_d   = '0;
    if (partial && !tmo_hit) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  always_comb begin
    tmo_hit = 1'b0;
  end
`endif

  always_comb begin
    state_d      = state_q;
    burst_len_d  = burst_len_q;
    issued_d     = issued_q + CntW'(fifo_rd_en);
    beat_cnt_d   = beat_cnt_q + CntW'(pop);
    burst_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_count >= BurstLen) begin
          state_d     = StDrain;
          burst_len_d = BurstLen;
          issued_d    = '0;
          beat_cnt_d  = '0;
        end else if (tmo_hit) begin
          state_d     = StDrain;
          burst_len_d = fifo_count;
          issued_d    = '0;
          beat_cnt_d  = '0;
        end
      end
      StDrain: begin
        if (issued_q == burst_len_q) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (pop && m_last) begin
          state_d      = StIdle;
          burst_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer: push the word read last cycle, pop on handshake.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_occ_d = buf_occ_q;
    unique case ({inflight_q, pop})
      2'b10: begin
        if (buf_occ_q == 2'd0) begin
          buf0_d = fifo_rd_data;
        end else begin
          buf1_d = fifo_rd_data;
        end
        buf_occ_d = buf_occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_occ_d = buf_occ_q - 2'd1;
      end
      2'b11: begin
        if (buf_occ_q == 2'd1) begin
          buf0_d = fifo_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      burst_len_q  <= '0;
      issued_q     <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      buf_occ_q    <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_len_q  <= burst_len_d;
      issued_q     <= issued_d;
      beat_cnt_q   <= beat_cnt_d;
      inflight_q   <= fifo_rd_en;
      buf_occ_q    <= buf_occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      burst_done_q <= burst_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural FIFO, beat monitor and
// scenario tasks compared against expectations derived from the burst rules.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int FD = 16;
  localparam int BL = 4;
  localparam int TO = 16;
  localparam int CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic          burst_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (FD),
    .BURST_LEN     (BL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_count  (fifo_count),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .burst_done  (burst_done)
  );

  // Behavioural FIFO: registered read data, occupancy from pointers.
  logic [DW-1:0] fmem [0:4095];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic fifo_clr = 1'b0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  assign fifo_count = CW'(wr_ptr - rd_ptr);

  // Monitor: cycle stamps of accepted beats, reads and burst_done pulses.
  int            cyc = 0;
  logic [DW-1:0] ob_d[$];
  bit            ob_l[$];
  int            ob_c[$];
  int            rd_c[$];
  int            done_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        ob_d.push_back(m_data);
        ob_l.push_back(m_last);
        ob_c.push_back(cyc);
      end
      if (fifo_rd_en) rd_c.push_back(cyc);
      if (burst_done) done_c.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int k = 0;
    while ((done_c.size() < target) && (k < budget)) begin
      step(1);
      k++;
    end
    ok = (done_c.size() >= target);
  endtask

  task automatic test_reset();
    logic [DW+4:0] outs;
    int k;
    rst_n = 1'b0;
    step(2);
    outs = {fifo_rd_en, m_valid, m_last, busy, burst_done, m_data};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_initial: outputs %h required 0", outs);
    end
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < BL; i++) push(DW'(8'hA1 + i));
    k = 0;
    while (!busy && k < 5) begin
      step(1);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_enter_drain: busy %b required 1", busy);
    end
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    outs = {fifo_rd_en, m_valid, m_last, busy, burst_done, m_data};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_async_midburst: outputs %h required 0", outs);
    end
    step(1);
    fifo_clr = 1'b1;
    step(1);
    fifo_clr = 1'b0;
    rst_n = 1'b1;
    step(3);
    outs = {fifo_rd_en, m_valid, m_last, busy, burst_done, m_data};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_release_idle: outputs %h required 0", outs);
    end
  endtask

  task automatic test_full_burst();
    int b_ob, b_rd, b_dn, c;
    bit ok;
    m_ready = 1'b1;
    b_ob = ob_d.size(); b_rd = rd_c.size(); b_dn = done_c.size();
    c = cyc;
    for (int i = 0; i < BL; i++) push(DW'(8'h11 + i));
    wait_done(b_dn + 1, 40, ok);
    step(2);
    n_cmp++;
    if (!ok || (ob_d.size() - b_ob) != BL) begin
      n_err++;
      $display("FAIL full_beats: got %0d beats done=%b required %0d", ob_d.size() - b_ob, ok, BL);
    end else begin
      for (int i = 0; i < BL; i++) begin
        n_cmp++;
        if (ob_d[b_ob+i] !== DW'(8'h11 + i) || ob_l[b_ob+i] !== (i == BL - 1) ||
            ob_c[b_ob+i] != c + 3 + i) begin
          n_err++;
          $display("FAIL full_beat%0d: data %h last %b cyc %0d required %h %b %0d", i,
                   ob_d[b_ob+i], ob_l[b_ob+i], ob_c[b_ob+i] - c, DW'(8'h11 + i), i == BL - 1,
                   3 + i);
        end
      end
      n_cmp++;
      if ((rd_c.size() - b_rd) != BL || rd_c[b_rd] != c + 1) begin
        n_err++;
        $display("FAIL full_reads: count %0d required %0d (first at +1)", rd_c.size() - b_rd, BL);
      end
      n_cmp++;
      if (done_c[b_dn] != c + 7) begin
        n_err++;
        $display("FAIL full_done: cyc +%0d required +7", done_c[b_dn] - c);
      end
    end
  endtask

  task automatic test_backpressure();
    int b_ob, b_rd, b_dn;
    bit ok;
    m_ready = 1'b0;
    b_ob = ob_d.size(); b_rd = rd_c.size(); b_dn = done_c.size();
    for (int i = 0; i < BL; i++) push(DW'(8'h11 + i));
    step(3);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'h11 || m_last !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid %b data %h last %b required 1 11 0", i, m_valid,
                 m_data, m_last);
      end
      step(1);
    end
    n_cmp++;
    if ((rd_c.size() - b_rd) != 2) begin
      n_err++;
      $display("FAIL bp_reads: %0d pops required 2", rd_c.size() - b_rd);
    end
    m_ready = 1'b1;
    wait_done(b_dn + 1, 40, ok);
    step(2);
    n_cmp++;
    if (!ok || (ob_d.size() - b_ob) != BL || (rd_c.size() - b_rd) != BL) begin
      n_err++;
      $display("FAIL bp_complete: beats %0d reads %0d required %0d", ob_d.size() - b_ob,
               rd_c.size() - b_rd, BL);
    end else begin
      for (int i = 0; i < BL; i++) begin
        n_cmp++;
        if (ob_d[b_ob+i] !== DW'(8'h11 + i) || ob_l[b_ob+i] !== (i == BL - 1)) begin
          n_err++;
          $display("FAIL bp_beat%0d: data %h last %b required %h %b", i, ob_d[b_ob+i],
                   ob_l[b_ob+i], DW'(8'h11 + i), i == BL - 1);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int b_ob, b_dn;
    bit ok;
    bit bad = 1'b0;
    m_ready = 1'b1;
    b_ob = ob_d.size(); b_dn = done_c.size();
    push(8'h31);
    push(8'h32);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (busy || fifo_rd_en) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL starve_wait: busy/read seen with 2 words, required none");
    end
    push(8'h33);
    push(8'h34);
    wait_done(b_dn + 1, 40, ok);
    step(2);
    n_cmp++;
    if (!ok || (ob_d.size() - b_ob) != BL) begin
      n_err++;
      $display("FAIL starve_beats: %0d required %0d", ob_d.size() - b_ob, BL);
    end else begin
      for (int i = 0; i < BL; i++) begin
        n_cmp++;
        if (ob_d[b_ob+i] !== DW'(8'h31 + i) || ob_l[b_ob+i] !== (i == BL - 1)) begin
          n_err++;
          $display("FAIL starve_beat%0d: data %h last %b required %h %b", i, ob_d[b_ob+i],
                   ob_l[b_ob+i], DW'(8'h31 + i), i == BL - 1);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int b_ob, b_rd, b_dn, c;
`ifdef FIFO_RD_TIMEOUT_EN
    int  cb = -1;
    bit  ok;
    m_ready = 1'b1;
    b_ob = ob_d.size(); b_dn = done_c.size();
    c = cyc;
    for (int i = 0; i < 3; i++) push(DW'(8'h41 + i));
    for (int k = 0; k < 40 && cb < 0; k++) begin
      step(1);
      if (busy) cb = cyc;
    end
    n_cmp++;
    if (cb != c + TO) begin
      n_err++;
      $display("FAIL tmo_enter: drain at +%0d required +%0d", cb - c, TO);
    end
    wait_done(b_dn + 1, 40, ok);
    step(2);
    n_cmp++;
    if (!ok || (ob_d.size() - b_ob) != 3) begin
      n_err++;
      $display("FAIL tmo_beats: %0d required 3", ob_d.size() - b_ob);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (ob_d[b_ob+i] !== DW'(8'h41 + i) || ob_l[b_ob+i] !== (i == 2)) begin
          n_err++;
          $display("FAIL tmo_beat%0d: data %h last %b required %h %b", i, ob_d[b_ob+i],
                   ob_l[b_ob+i], DW'(8'h41 + i), i == 2);
        end
      end
    end
    b_rd = rd_c.size();
`else
    bit bad = 1'b0;
    m_ready = 1'b1;
    b_ob = ob_d.size(); b_rd = rd_c.size(); b_dn = done_c.size();
    c = cyc;
    for (int i = 0; i < 3; i++) push(DW'(8'h41 + i));
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (busy || fifo_rd_en) bad = 1'b1;
    end
    n_cmp++;
    if (bad || (rd_c.size() != b_rd) || (ob_d.size() != b_ob) || (done_c.size() != b_dn)) begin
      n_err++;
      $display("FAIL notmo_idle: activity over %0d cycles with 3 words, required none", cyc - c);
    end
    n_cmp++;
    if (fifo_count !== CW'(3)) begin
      n_err++;
      $display("FAIL notmo_count: fifo_count %0d required 3", fifo_count);
    end
    fifo_clr = 1'b1;
    step(1);
    fifo_clr = 1'b0;
    step(1);
`endif
  endtask

  task automatic test_back_to_back();
    int b_ob, b_dn, c, exp_c;
    bit ok;
    m_ready = 1'b1;
    b_ob = ob_d.size(); b_dn = done_c.size();
    c = cyc;
    for (int i = 0; i < 2 * BL; i++) push(DW'(8'h51 + i));
    wait_done(b_dn + 2, 60, ok);
    step(2);
    n_cmp++;
    if (!ok || (ob_d.size() - b_ob) != 2 * BL || (done_c.size() - b_dn) != 2) begin
      n_err++;
      $display("FAIL b2b_count: beats %0d dones %0d required %0d 2", ob_d.size() - b_ob,
               done_c.size() - b_dn, 2 * BL);
    end else begin
      for (int i = 0; i < 2 * BL; i++) begin
        exp_c = (i < BL) ? c + 3 + i : c + 10 + (i - BL);
        n_cmp++;
        if (ob_d[b_ob+i] !== DW'(8'h51 + i) || ob_l[b_ob+i] !== ((i % BL) == BL - 1) ||
            ob_c[b_ob+i] != exp_c) begin
          n_err++;
          $display("FAIL b2b_beat%0d: data %h last %b cyc +%0d required %h %b +%0d", i,
                   ob_d[b_ob+i], ob_l[b_ob+i], ob_c[b_ob+i] - c, DW'(8'h51 + i),
                   (i % BL) == BL - 1, exp_c - c);
        end
      end
      n_cmp++;
      if (done_c[b_dn] != c + 7 || done_c[b_dn+1] != c + 14) begin
        n_err++;
        $display("FAIL b2b_done: +%0d +%0d required +7 +14", done_c[b_dn] - c,
                 done_c[b_dn+1] - c);
      end
    end
  endtask

  // Random data and ready; words arrive in whole bursts so every word must come out in order.
  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    int  b_ob, b_dn, n_chunks, pushed, got;
    bit  ok;
    b_ob = ob_d.size(); b_dn = done_c.size();
    n_chunks = $urandom_range(4, 8);
    pushed = 0;
    for (int k = 0; k < 800 && pushed < n_chunks; k++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (fifo_count <= CW'(FD - BL) && $urandom_range(0, 2) == 0) begin
        for (int i = 0; i < BL; i++) begin
          logic [DW-1:0] d;
          d = DW'($urandom);
          push(d);
          exp_q.push_back(d);
        end
        pushed++;
      end
      step(1);
    end
    for (int k = 0; k < 400 && done_c.size() < b_dn + pushed; k++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    m_ready = 1'b1;
    wait_done(b_dn + pushed, 40, ok);
    step(2);
    got = ob_d.size() - b_ob;
    n_cmp++;
    if (!ok || got != exp_q.size() || (done_c.size() - b_dn) != pushed) begin
      n_err++;
      $display("FAIL rnd_count: beats %0d dones %0d required %0d %0d", got,
               done_c.size() - b_dn, exp_q.size(), pushed);
    end
    for (int i = 0; i < got && i < exp_q.size(); i++) begin
      n_cmp++;
      if (ob_d[b_ob+i] !== exp_q[i] || ob_l[b_ob+i] !== ((i % BL) == BL - 1)) begin
        n_err++;
        $display("FAIL rnd_beat%0d: data %h last %b required %h %b", i, ob_d[b_ob+i],
                 ob_l[b_ob+i], exp_q[i], (i % BL) == BL - 1);
      end
    end
    n_cmp++;
    if (fifo_count !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_end: fifo_count %0d busy %b required 0 0", fifo_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    step(3);
    test_backpressure();
    step(3);
    test_starvation();
    step(3);
    test_timeout();
    step(3);
    test_back_to_back();
    step(3);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
